// File: rtl/pwm_dac_out_pkg.sv
// rtl/pwm_dac_out_pkg.sv - gain state encoding, shared constants and duty scaling for pwm_dac_out
package pwm_dac_out_pkg;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'b00,
        ST_RAMP_DOWN = 2'b01,
        ST_MUTED     = 2'b10,
        ST_RAMP_UP   = 2'b11
    } gain_state_e;

    localparam logic [7:0] MIDSCALE  = 8'd128;
    localparam logic [4:0] GAIN_FULL = 5'd16;

    // Scales the sample's distance from midscale by gain/16; the shift floors toward -inf,
    // so gain 16 reproduces the sample exactly and the result always fits in 0..255.
    function automatic logic [7:0] scale_duty(input logic [7:0] hold, input logic [4:0] gain);
        logic signed [8:0]  diff;
        logic signed [12:0] diff_x;
        logic signed [12:0] gain_x;
        logic signed [12:0] prod;
        logic signed [12:0] duty_x;
        diff   = $signed({1'b0, hold} - {1'b0, MIDSCALE});
        diff_x = {{4{diff[8]}}, diff};
        gain_x = {8'd0, gain};
        prod   = diff_x * gain_x;
        duty_x = (prod >>> 4) + $signed({5'd0, MIDSCALE});
        return duty_x[7:0];
    endfunction

endpackage

// File: rtl/pwm_dac_out_mute_ramp.sv
// rtl/pwm_dac_out_mute_ramp.sv - mute gain state machine (soft ramp when SOFT_MUTE_EN is defined)
module mute_ramp
    import pwm_dac_out_pkg::*;
#(
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boundary,
    input  logic       mute,
    output logic [4:0] gain,
    output logic       muted
);

    gain_state_e state_q, state_d;
    logic [4:0]  gain_q, gain_d;

`ifdef SOFT_MUTE_EN
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic [RW-1:0] ramp_q, ramp_d;
    logic          ramp_done;

    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        ramp_d    = ramp_q;
        ramp_done = (ramp_q == RW'(RAMP_PERIODS - 1));
        if (boundary) begin
            case (state_q)
                ST_PLAY: begin
                    if (mute) state_d = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (!mute) begin
                        state_d = ST_RAMP_UP;
                    end else if (ramp_done) begin
                        // A reversal can leave the ramp at either end, so clamp instead of wrapping.
                        if (gain_q <= 5'd1) begin
                            gain_d  = 5'd0;
                            state_d = ST_MUTED;
                        end else begin
                            gain_d = gain_q - 5'd1;
                        end
                    end
                end
                ST_MUTED: begin
                    if (!mute) state_d = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (mute) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (ramp_done) begin
                        if (gain_q >= GAIN_FULL - 5'd1) begin
                            gain_d  = GAIN_FULL;
                            state_d = ST_PLAY;
                        end else begin
                            gain_d = gain_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_PLAY;
                    gain_d  = GAIN_FULL;
                end
            endcase

            if ((state_d != state_q) || ramp_done) begin
                ramp_d = '0;
            end else if ((state_q == ST_RAMP_DOWN) || (state_q == ST_RAMP_UP)) begin
                ramp_d = ramp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (boundary) begin
            if (mute) begin
                state_d = ST_MUTED;
                gain_d  = 5'd0;
            end else begin
                state_d = ST_PLAY;
                gain_d  = GAIN_FULL;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PLAY;
            gain_q  <= GAIN_FULL;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    assign gain  = gain_q;
    assign muted = (state_q == ST_MUTED);

endmodule

// File: rtl/pwm_dac_out.sv
// rtl/pwm_dac_out.sv - 8-bit sample to PWM audio output with period-synchronous duty and mute ramp (SOFT_MUTE_EN)
module pwm_dac_out
    import pwm_dac_out_pkg::*;
#(
    parameter int CLK_DIV      = 1,
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       mute,
    output logic       pwm_out,
    output logic       sample_req,
    output logic       muted
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    hold_q, hold_d;
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          req_q, req_d;
    logic          tick;
    logic          boundary;
    logic [4:0]    gain;

    always_comb begin
        tick     = (pre_q == PW'(CLK_DIV - 1));
        boundary = tick && (cnt_q == 8'd255);
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        hold_d   = sample_valid ? sample_in : hold_q;
        // hold_q and gain are still the pre-boundary values here, so a sample strobed
        // on the boundary cycle waits for the next period.
        duty_d   = boundary ? scale_duty(hold_q, gain) : duty_q;
        pwm_d    = (cnt_q < duty_q);
        req_d    = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= 8'd0;
            hold_q <= MIDSCALE;
            duty_q <= MIDSCALE;
            pwm_q  <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            req_q  <= req_d;
        end
    end

    mute_ramp #(
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_mute_ramp (
        .clk      (clk),
        .rst      (rst),
        .boundary (boundary),
        .mute     (mute),
        .gain     (gain),
        .muted    (muted)
    );

    assign pwm_out    = pwm_q;
    assign sample_req = req_q;

endmodule
